peak_event_collector: RTL and testbench

PEAK_EVENT_COLLECTOR -- requirements
Module: peak_event_collector

---
 rtl/peak_pkg.sv | 27 ++
 rtl/peak_evt_fifo.sv | 73 +++++++
 rtl/peak_event_collector.sv | 132 +++++++++++++
 tb/tb_peak_event_collector.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/peak_pkg.sv
// Shared definitions for the peak event collector.
//   state_t    : collector FSM states
//   peak_evt_t : event record layout at the default sample width
//                (field order is identical for any DATA_WIDTH)
//   evt_width  : packed event width for a given DATA_WIDTH
package peak_pkg;

    localparam int          DEFAULT_DATA_WIDTH = 16;
    localparam logic [15:0] LEN_MAX            = 16'hFFFF;

    typedef enum logic {
        IDLE,
        IN_PEAK
    } state_t;

    typedef struct packed {
        logic [31:0]                          start_ts;
        logic [15:0]                          length;
        logic signed [DEFAULT_DATA_WIDTH-1:0] max_mean;
        logic [2*DEFAULT_DATA_WIDTH-1:0]      start_var;
    } peak_evt_t;

    function automatic int evt_width(input int dw);
        return 32 + 16 + dw + 2 * dw;
    endfunction

endpackage

// File: rtl/peak_evt_fifo.sv
// Event FIFO for the peak event collector.
// Shift-register organisation: entry 0 is always the head, so dout, empty
// and full all come straight from flops.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored when full unless popping)
//   pop        : read request (ignored when empty)
//   dout       : head entry
//   empty/full : registered occupancy flags
module peak_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem   [DEPTH];
    logic [WIDTH-1:0] mem_n [DEPTH];
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic [CW-1:0]    widx;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign do_push = push & (~full | do_pop);
    assign widx    = cnt - CW'(do_pop);
    assign cnt_n   = cnt + CW'(do_push) - CW'(do_pop);
    assign dout    = mem[0];

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_n[i] = mem[i];
        end
        if (do_pop) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                mem_n[i] = mem[i+1];
            end
            mem_n[DEPTH-1] = '0;
        end
        if (do_push) begin
            mem_n[widx[CW-2:0]] = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            cnt   <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= mem_n[i];
            end
            cnt   <= cnt_n;
            empty <= (cnt_n == '0);
            full  <= (cnt_n == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/peak_event_collector.sv
// Collects runs of peak-flagged samples into event records and queues them.
//   clk, rst_n     : clock, asynchronous active-low reset
//   valid_in       : sample strobe; peak_in/mean_in/variance_in qualified by it
//   flush          : closes an open event without waiting for a non-peak sample
//   evt_valid      : FIFO head holds an event; popped when evt_ready is high
//   evt_start_ts   : sample index of the first peak sample
//   evt_length     : peak sample count, saturating
//   evt_max_mean   : signed maximum mean over the event
//   evt_start_var  : variance at the first peak sample
//   drop_count     : events lost to a full FIFO, saturating
module peak_event_collector
    import peak_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic                    peak_in,
    input  logic [DATA_WIDTH-1:0]   mean_in,
    input  logic [2*DATA_WIDTH-1:0] variance_in,
    input  logic                    flush,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [31:0]             evt_start_ts,
    output logic [15:0]             evt_length,
    output logic [DATA_WIDTH-1:0]   evt_max_mean,
    output logic [2*DATA_WIDTH-1:0] evt_start_var,
    output logic [15:0]             drop_count
);

    localparam int EW = evt_width(DATA_WIDTH);

    state_t                  state;
    logic [31:0]             ts;
    logic [31:0]             cur_ts;
    logic [15:0]             cur_len;
    logic [DATA_WIDTH-1:0]   cur_max;
    logic [2*DATA_WIDTH-1:0] cur_var;
    logic [15:0]             upd_len;
    logic [DATA_WIDTH-1:0]   upd_max;

    logic                    push_q;
    logic [EW-1:0]           push_data;
    logic [EW-1:0]           head;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    pop;

    assign evt_valid = ~fifo_empty;
    assign pop       = evt_valid & evt_ready;

    // Running event updated with the current peak sample.
    always_comb begin
        upd_len = (cur_len == LEN_MAX) ? cur_len : cur_len + 16'd1;
        upd_max = ($signed(mean_in) > $signed(cur_max)) ? mean_in : cur_max;
    end

    // The finished event is registered here and written into the FIFO on
    // the following edge, so it never appears in the cycle it terminates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ts         <= '0;
            cur_ts     <= '0;
            cur_len    <= '0;
            cur_max    <= '0;
            cur_var    <= '0;
            push_q     <= 1'b0;
            push_data  <= '0;
            drop_count <= '0;
        end else begin
            push_q <= 1'b0;
            if (valid_in) begin
                ts <= ts + 32'd1;
            end
            if (push_q && fifo_full && !pop && drop_count != LEN_MAX) begin
                drop_count <= drop_count + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (valid_in && peak_in) begin
                        cur_ts  <= ts;
                        cur_len <= 16'd1;
                        cur_max <= mean_in;
                        cur_var <= variance_in;
                        state   <= IN_PEAK;
                    end
                end
                IN_PEAK: begin
                    if (valid_in && peak_in) begin
                        if (flush) begin
                            push_q    <= 1'b1;
                            push_data <= {cur_ts, upd_len, upd_max, cur_var};
                            state     <= IDLE;
                        end else begin
                            cur_len <= upd_len;
                            cur_max <= upd_max;
                        end
                    end else if (valid_in || flush) begin
                        push_q    <= 1'b1;
                        push_data <= {cur_ts, cur_len, cur_max, cur_var};
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    peak_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_q),
        .din   (push_data),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign evt_start_ts  = head[EW-1 -: 32];
    assign evt_length    = head[EW-33 -: 16];
    assign evt_max_mean  = head[3*DATA_WIDTH-1 -: DATA_WIDTH];
    assign evt_start_var = head[2*DATA_WIDTH-1:0];

endmodule

// File: tb/tb_peak_event_collector.sv
module tb_peak_event_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        peak_in;
    logic [15:0] mean_in;
    logic [31:0] variance_in;
    logic        flush;
    logic        evt_valid;
    logic        evt_ready;
    logic [31:0] evt_start_ts;
    logic [15:0] evt_length;
    logic [15:0] evt_max_mean;
    logic [31:0] evt_start_var;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;
    int m_ts   = 0;

    always #5 clk = ~clk;

    peak_event_collector #(
        .DATA_WIDTH (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_in      (valid_in),
        .peak_in       (peak_in),
        .mean_in       (mean_in),
        .variance_in   (variance_in),
        .flush         (flush),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_start_ts  (evt_start_ts),
        .evt_length    (evt_length),
        .evt_max_mean  (evt_max_mean),
        .evt_start_var (evt_start_var),
        .drop_count    (drop_count)
    );

    typedef struct {
        logic        v;
        logic        p;
        logic [15:0] m;
        logic [31:0] vr;
        logic        rdy;
        logic        ev;
        logic [31:0] ets;
        logic [15:0] elen;
        logic [15:0] emax;
        logic [31:0] evar;
    } vec_t;

    vec_t vec [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drives one cycle starting at a negedge; returns at the next negedge.
    task automatic cyc(input logic v, input logic p, input logic [15:0] m,
                       input logic [31:0] vr, input logic f);
        valid_in    = v;
        peak_in     = p;
        mean_in     = m;
        variance_in = vr;
        flush       = f;
        @(negedge clk);
        if (v) m_ts++;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 16'd0, 32'd0, 1'b0);
    endtask

    task automatic pop_check(input string name, input logic [31:0] ets,
                             input logic [15:0] elen, input logic [15:0] emax);
        chk({name, ".valid"}, 64'(evt_valid), 64'd1);
        chk({name, ".ts"}, 64'(evt_start_ts), 64'(ets));
        chk({name, ".len"}, 64'(evt_length), 64'(elen));
        chk({name, ".max"}, 64'(evt_max_mean), 64'(emax));
        evt_ready = 1'b1;
        idle();
        evt_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        evt_ready = 1'b0;
        valid_in = 1'b0; peak_in = 1'b0; flush = 1'b0;
        mean_in = '0; variance_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ts = 0;
        @(negedge clk);
    endtask

    task automatic one_event(input logic [15:0] m);
        cyc(1'b1, 1'b1, m, 32'd0, 1'b0);
        cyc(1'b1, 1'b0, 16'd0, 32'd0, 1'b0);
    endtask

    initial begin
        logic [31:0] st;
        logic [31:0] ets [6];

        // Peak run: valid on ts 0..9, peaks on 3..5; terminated by the ts-6
        // sample, visible after the ts-7 edge, popped by the last vector.
        vec[0]  = '{1, 0, 16'd0,  32'd0,   0, 0, 32'd0, 16'd0, 16'd0,  32'd0};
        vec[1]  = '{1, 0, 16'd0,  32'd100, 0, 0, 32'd0, 16'd0, 16'd0,  32'd0};
        vec[2]  = '{1, 0, 16'd0,  32'd200, 0, 0, 32'd0, 16'd0, 16'd0,  32'd0};
        vec[3]  = '{1, 1, 16'd10, 32'd300, 0, 0, 32'd0, 16'd0, 16'd0,  32'd0};
        vec[4]  = '{1, 1, 16'd40, 32'd400, 0, 0, 32'd0, 16'd0, 16'd0,  32'd0};
        vec[5]  = '{1, 1, 16'd20, 32'd500, 0, 0, 32'd0, 16'd0, 16'd0,  32'd0};
        vec[6]  = '{1, 0, 16'd0,  32'd600, 0, 0, 32'd0, 16'd0, 16'd0,  32'd0};
        vec[7]  = '{1, 0, 16'd0,  32'd700, 0, 1, 32'd3, 16'd3, 16'd40, 32'd300};
        vec[8]  = '{1, 0, 16'd0,  32'd800, 0, 1, 32'd3, 16'd3, 16'd40, 32'd300};
        vec[9]  = '{1, 0, 16'd0,  32'd900, 0, 1, 32'd3, 16'd3, 16'd40, 32'd300};
        vec[10] = '{0, 0, 16'd0,  32'd0,   1, 0, 32'd0, 16'd0, 16'd0,  32'd0};

        rst_n = 1'b0;
        evt_ready = 1'b0;
        valid_in = 1'b0; peak_in = 1'b0; flush = 1'b0;
        mean_in = '0; variance_in = '0;
        repeat (2) @(negedge clk);
        chk("rst.valid", 64'(evt_valid), 64'd0);
        chk("rst.ts", 64'(evt_start_ts), 64'd0);
        chk("rst.len", 64'(evt_length), 64'd0);
        chk("rst.max", 64'(evt_max_mean), 64'd0);
        chk("rst.var", 64'(evt_start_var), 64'd0);
        chk("rst.drop", 64'(drop_count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            evt_ready = vec[i].rdy;
            cyc(vec[i].v, vec[i].p, vec[i].m, vec[i].vr, 1'b0);
            chk($sformatf("vec%0d.valid", i), 64'(evt_valid), 64'(vec[i].ev));
            if (vec[i].ev) begin
                chk($sformatf("vec%0d.ts", i), 64'(evt_start_ts), 64'(vec[i].ets));
                chk($sformatf("vec%0d.len", i), 64'(evt_length), 64'(vec[i].elen));
                chk($sformatf("vec%0d.max", i), 64'(evt_max_mean), 64'(vec[i].emax));
                chk($sformatf("vec%0d.var", i), 64'(evt_start_var), 64'(vec[i].evar));
            end
        end
        evt_ready = 1'b0;

        // Negative means: signed maximum.
        st = 32'(m_ts);
        cyc(1'b1, 1'b1, -16'sd5, 32'd0, 1'b0);
        cyc(1'b1, 1'b1, -16'sd2, 32'd0, 1'b0);
        cyc(1'b1, 1'b1, -16'sd9, 32'd0, 1'b0);
        cyc(1'b1, 1'b0, 16'd0, 32'd0, 1'b0);
        idle();
        pop_check("neg", st, 16'd3, 16'hFFFE);
        chk("neg.empty", 64'(evt_valid), 64'd0);

        // Overflow: six events into a four-entry FIFO with no consumer.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            ets[k] = 32'(m_ts);
            one_event(16'(k * 10 + 1));
        end
        idle();
        idle();
        chk("ovf.drop", 64'(drop_count), 64'd2);
        for (int k = 0; k < 4; k++) begin
            pop_check($sformatf("ovf%0d", k), ets[k], 16'd1, 16'(k * 10 + 1));
        end
        chk("ovf.empty", 64'(evt_valid), 64'd0);

        // Full FIFO: push and pop on the same edge.
        for (int k = 0; k < 4; k++) begin
            ets[k] = 32'(m_ts);
            one_event(16'(k + 100));
        end
        idle();
        chk("full.drop0", 64'(drop_count), 64'd2);
        ets[4] = 32'(m_ts);
        one_event(16'd77);
        // The event is written on the next edge; pop the head on that edge.
        evt_ready = 1'b1;
        idle();
        evt_ready = 1'b0;
        idle();
        chk("full.drop1", 64'(drop_count), 64'd2);
        for (int k = 1; k < 4; k++) begin
            pop_check($sformatf("full%0d", k), ets[k], 16'd1, 16'(k + 100));
        end
        pop_check("full.new", ets[4], 16'd1, 16'd77);
        chk("full.empty", 64'(evt_valid), 64'd0);

        // Flush without a sample closes a two-sample run.
        st = 32'(m_ts);
        cyc(1'b1, 1'b1, 16'd5, 32'd0, 1'b0);
        cyc(1'b1, 1'b1, 16'd7, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 16'd0, 32'd0, 1'b1);
        chk("fl2.notyet", 64'(evt_valid), 64'd0);
        idle();
        pop_check("fl2", st, 16'd2, 16'd7);

        // Flush with a peak sample includes that sample.
        st = 32'(m_ts);
        cyc(1'b1, 1'b1, 16'd3, 32'd0, 1'b0);
        cyc(1'b1, 1'b1, 16'd9, 32'd0, 1'b0);
        cyc(1'b1, 1'b1, 16'd4, 32'd0, 1'b1);
        idle();
        pop_check("fl3", st, 16'd3, 16'd9);

        // Flush in IDLE does nothing.
        cyc(1'b0, 1'b0, 16'd0, 32'd0, 1'b1);
        cyc(1'b0, 1'b0, 16'd0, 32'd0, 1'b1);
        idle();
        chk("flidle.valid", 64'(evt_valid), 64'd0);
        chk("flidle.drop", 64'(drop_count), 64'd2);

        // Reset during an open event with two queued events.
        one_event(16'd1);
        one_event(16'd2);
        cyc(1'b1, 1'b1, 16'd3, 32'd0, 1'b0);
        chk("mid.queued", 64'(evt_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid.valid", 64'(evt_valid), 64'd0);
        chk("mid.drop", 64'(drop_count), 64'd0);
        chk("mid.ts", 64'(evt_start_ts), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ts = 0;
        idle();
        idle();
        chk("mid.nopush", 64'(evt_valid), 64'd0);
        cyc(1'b1, 1'b1, 16'd55, 32'd0, 1'b0);
        cyc(1'b1, 1'b1, 16'd3, 32'd0, 1'b0);
        cyc(1'b1, 1'b0, 16'd0, 32'd0, 1'b0);
        idle();
        pop_check("mid.after", 32'd0, 16'd2, 16'd55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
